// File: rtl/regwrite_arbiter_if.sv
// Writeback bus between the three requesters, the register-file write port,
// the hazard logic (busy) and the optional read-bypass lookup.
interface regwrite_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                       alu_valid, mem_valid, lnk_valid;
  logic [ADDR_W-1:0]          alu_addr,  mem_addr,  lnk_addr;
  logic [DATA_W-1:0]          alu_data,  mem_data,  lnk_data;
  logic                       alu_ready, mem_ready, lnk_ready;
  logic                       RegWrite;
  logic [ADDR_W-1:0]          writeReg;
  logic [DATA_W-1:0]          writeData;
  logic [(32'd1<<ADDR_W)-1:0] busy;
  logic [ADDR_W-1:0]          rd_addr1, rd_addr2;
  logic                       byp_hit1, byp_hit2;
  logic [DATA_W-1:0]          byp_data1, byp_data2;

  modport master (
    output alu_valid, mem_valid, lnk_valid, alu_addr, mem_addr, lnk_addr,
           alu_data, mem_data, lnk_data, rd_addr1, rd_addr2,
    input  alu_ready, mem_ready, lnk_ready, RegWrite, writeReg, writeData,
           busy, byp_hit1, byp_hit2, byp_data1, byp_data2
  );

  modport slave (
    input  alu_valid, mem_valid, lnk_valid, alu_addr, mem_addr, lnk_addr,
           alu_data, mem_data, lnk_data, rd_addr1, rd_addr2,
    output alu_ready, mem_ready, lnk_ready, RegWrite, writeReg, writeData,
           busy, byp_hit1, byp_hit2, byp_data1, byp_data2
  );
endinterface

// File: rtl/regwrite_arbiter.sv
// Round-robin arbiter sharing the register-file write port among ALU/MEM/LNK
// holding slots. Define REGWRITE_BYPASS_EN to build the read-bypass compare logic.
module regwrite_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  regwrite_arbiter_if.slave bus
);
  localparam int NSRC = 3;
  localparam int NREG = 32'd1 << ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [NREG-1:0]   vec_t;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    logic [1:0] r;
    case (x)
      2'd0:    r = 2'd1;
      2'd1:    r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  logic [NSRC-1:0] in_valid_s;
  addr_t           in_addr_s [NSRC];
  data_t           in_data_s [NSRC];

  logic [NSRC-1:0] slot_full_r;
  addr_t           slot_addr_r [NSRC];
  data_t           slot_data_r [NSRC];
  // older_r[i][j] set when slot i was accepted before slot j
  logic [NSRC-1:0] older_r    [NSRC];
  logic [NSRC-1:0] older_nx_s [NSRC];
  logic [1:0]      rr_r;
  logic            we_r;
  addr_t           wa_r;
  data_t           wd_r;

  logic [NSRC-1:0] blk_s, elig_s, grant_s, zero_s, ready_s, acc_s, stay_s;
  logic [1:0]      gidx_s, cand_s;
  logic            gvalid_s;
  vec_t            busy_s;

  assign in_valid_s   = {bus.lnk_valid, bus.mem_valid, bus.alu_valid};
  assign in_addr_s[0] = bus.alu_addr;
  assign in_addr_s[1] = bus.mem_addr;
  assign in_addr_s[2] = bus.lnk_addr;
  assign in_data_s[0] = bus.alu_data;
  assign in_data_s[1] = bus.mem_data;
  assign in_data_s[2] = bus.lnk_data;

  // WAW ordering: a slot waits while an older full slot targets the same register
  always_comb begin
    blk_s  = '0;
    zero_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      zero_s[i] = (in_addr_s[i] == '0);
      for (int j = 0; j < NSRC; j++) begin
        blk_s[i] = blk_s[i] | (slot_full_r[j] & older_r[j][i] &
                               (slot_addr_r[j] == slot_addr_r[i]));
      end
    end
    elig_s = slot_full_r & ~blk_s;
  end

  // Round-robin scan starting at rr_r
  always_comb begin
    gvalid_s = 1'b0;
    gidx_s   = 2'd0;
    cand_s   = rr_r;
    for (int k = 0; k < NSRC; k++) begin
      if (!gvalid_s && elig_s[cand_s]) begin
        gvalid_s = 1'b1;
        gidx_s   = cand_s;
      end else begin
        gvalid_s = gvalid_s;
      end
      cand_s = inc3(cand_s);
    end
    grant_s = gvalid_s ? (3'b001 << gidx_s) : 3'b000;
  end

  // Handshake: r0 writes are swallowed, granted slots may refill on the same edge
  always_comb begin
    ready_s = zero_s | ~slot_full_r | grant_s;
    acc_s   = in_valid_s & ready_s & ~zero_s;
    stay_s  = slot_full_r & ~grant_s;
  end

  // Next age matrix: held entries stay older than new ones; same-cycle by index
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      older_nx_s[i] = '0;
      for (int j = 0; j < NSRC; j++) begin
        if (acc_s[i] && acc_s[j]) begin
          older_nx_s[i][j] = (i < j);
        end else if (acc_s[i]) begin
          older_nx_s[i][j] = 1'b0;
        end else if (stay_s[i] && acc_s[j]) begin
          older_nx_s[i][j] = 1'b1;
        end else if (stay_s[i] && stay_s[j]) begin
          older_nx_s[i][j] = older_r[i][j];
        end else begin
          older_nx_s[i][j] = 1'b0;
        end
      end
    end
  end

  // Slots, age matrix, round-robin pointer and registered write stage
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_full_r <= '0;
      for (int i = 0; i < NSRC; i++) begin
        slot_addr_r[i] <= '0;
        slot_data_r[i] <= '0;
        older_r[i]     <= '0;
      end
      rr_r <= 2'd0;
      we_r <= 1'b0;
      wa_r <= '0;
      wd_r <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (acc_s[i]) begin
          slot_full_r[i] <= 1'b1;
          slot_addr_r[i] <= in_addr_s[i];
          slot_data_r[i] <= in_data_s[i];
        end else if (grant_s[i]) begin
          slot_full_r[i] <= 1'b0;
        end
      end
      older_r <= older_nx_s;
      if (gvalid_s) begin
        rr_r <= inc3(gidx_s);
        we_r <= 1'b1;
        wa_r <= slot_addr_r[gidx_s];
        wd_r <= slot_data_r[gidx_s];
      end else begin
        we_r <= 1'b0;
      end
    end
  end

  // Busy vector for hazard detection; register 0 is never busy
  always_comb begin
    busy_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      busy_s = busy_s | (slot_full_r[i] ? (vec_t'(1'b1) << slot_addr_r[i]) : '0);
    end
    busy_s    = busy_s | (we_r ? (vec_t'(1'b1) << wa_r) : '0);
    busy_s[0] = 1'b0;
  end

  assign bus.alu_ready = ready_s[0];
  assign bus.mem_ready = ready_s[1];
  assign bus.lnk_ready = ready_s[2];
  assign bus.RegWrite  = we_r;
  assign bus.writeReg  = wa_r;
  assign bus.writeData = wd_r;
  assign bus.busy      = busy_s;

`ifdef REGWRITE_BYPASS_EN
  addr_t           rd_s     [2];
  logic [NSRC-1:0] match_s  [2];
  logic [NSRC-1:0] yng_s    [2];
  data_t           bd_s     [2];
  logic [1:0]      hit_s, wmatch_s;

  assign rd_s[0] = bus.rd_addr1;
  assign rd_s[1] = bus.rd_addr2;

  // Youngest matching slot wins; the write stage counts as oldest
  always_comb begin
    hit_s    = '0;
    wmatch_s = '0;
    for (int p = 0; p < 2; p++) begin
      match_s[p]  = '0;
      yng_s[p]    = '0;
      bd_s[p]     = '0;
      wmatch_s[p] = we_r & (wa_r == rd_s[p]) & (rd_s[p] != '0);
      for (int i = 0; i < NSRC; i++) begin
        match_s[p][i] = slot_full_r[i] & (slot_addr_r[i] == rd_s[p]) & (rd_s[p] != '0);
      end
      for (int i = 0; i < NSRC; i++) begin
        yng_s[p][i] = match_s[p][i];
        for (int j = 0; j < NSRC; j++) begin
          yng_s[p][i] = yng_s[p][i] & ~(match_s[p][j] & older_r[i][j]);
        end
        bd_s[p] = bd_s[p] | (yng_s[p][i] ? slot_data_r[i] : '0);
      end
      hit_s[p] = (|match_s[p]) | wmatch_s[p];
      bd_s[p]  = (|match_s[p]) ? bd_s[p] : (wmatch_s[p] ? wd_r : '0);
    end
  end

  assign bus.byp_hit1  = hit_s[0];
  assign bus.byp_hit2  = hit_s[1];
  assign bus.byp_data1 = bd_s[0];
  assign bus.byp_data2 = bd_s[1];
`else
  assign bus.byp_hit1  = 1'b0;
  assign bus.byp_hit2  = 1'b0;
  assign bus.byp_data1 = '0;
  assign bus.byp_data2 = '0;
`endif
endmodule

// File: doc/regwrite_arbiter.md
# regwrite_arbiter

Shares the register file's single write port among three writeback requesters: ALU result, memory load data and JAL link address. Each requester gets a one-entry holding slot with a valid/ready handshake. A round-robin arbiter drains one slot per cycle into a registered write stage that drives the register file's write-enable, write-address and write-data inputs. The block also exports a per-register busy vector for the hazard/stall logic and, optionally, a read-bypass path.

## Interface
- DATA_W, 32, writeback data width
- ADDR_W, 5, register address width (32 registers, register 0 hard-wired zero)
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- alu_valid / mem_valid / lnk_valid  input  1 each  requester has a write
- alu_addr / mem_addr / lnk_addr  input  ADDR_W each  destination register
- alu_data / mem_data / lnk_data  input  DATA_W each  write data
- alu_ready / mem_ready / lnk_ready  output  1 each  slot can accept this cycle
- RegWrite  output  1  registered write enable to register file
- writeReg  output  ADDR_W  registered write address
- writeData  output  DATA_W  registered write data
- busy  output  32  bit r set while any slot or the write stage targets register r; bit 0 always 0
- rd_addr1, rd_addr2  input  ADDR_W each  bypass lookup addresses
- byp_hit1, byp_hit2  output  1 each  bypass match
- byp_data1, byp_data2  output  DATA_W each  bypass data

## Operation
- Source index order: ALU=0, MEM=1, LNK=2.
- Handshake:
  - Transfer occurs when valid & ready at posedge.
  - ready = slot empty OR slot granted this cycle, which allows back-to-back transfers.
  - ready does not depend on valid.
- Writes with addr==0 are accepted with ready=1 regardless of slot state. They never occupy a slot, never set busy and never produce RegWrite.
- Age tracking: a 3x3 age matrix records relative acceptance order of full slots. Same-cycle acceptances are ordered ALU older than MEM older than LNK.
- Eligibility:
  - A full slot is eligible unless an older full slot holds the same address (WAW ordering).
  - At least one full slot is always eligible.
- Arbitration:
  - Round-robin pointer rr (2 bits, values 0..2).
  - Grant the first eligible slot scanning rr, rr+1, rr+2 mod 3.
  - After a grant, rr = granted index + 1 mod 3.
  - With no grant, rr holds.
- Write stage:
  - On a grant, the next posedge loads RegWrite=1, writeReg/writeData from the granted slot, and the slot empties unless refilled that same edge.
  - With no grant, RegWrite=0 and writeReg/writeData hold their previous values.
- busy: OR over full slots and the write stage (when RegWrite=1) of a one-hot decode of the address.

## Timing
- Reset (synchronous): all slots empty, age matrix cleared, rr=0, RegWrite=0, writeReg=0, writeData=0, busy=0, byp_hit*=0, byp_data*=0.
- Pending slots are discarded on reset. Reset takes precedence over simultaneous valid inputs.
- Latency:
  - Accept at edge k → RegWrite high in the cycle after edge k+1 if uncontended. Minimum is 2 edges.
  - The register file captures on the following negedge.
- Throughput: one write per cycle sustained. A slot refills on the same edge it is granted.
- All three slots full: each drained within 3 cycles. No source waits more than 2 grants while eligible.
- ready, busy and byp_* are combinational from registered state and current inputs. No path runs from valid to ready.

## Configuration
- REGWRITE_BYPASS_EN defined:
  - byp_hitN=1 when rd_addrN≠0 matches a full slot or an active write stage.
  - byp_dataN = the youngest match. Age order, youngest first: slots by age matrix, then the write stage as oldest.
- REGWRITE_BYPASS_EN undefined: the ports remain, with byp_hit*=0 and byp_data*=0 constant. No compare logic is built.

## Test plan
- Reset, then ALU writes r8=0x0000_00AA at edge 1 → RegWrite=1, writeReg=8, writeData=0xAA after edge 2. busy[8]=1 from edge 1 until RegWrite drops. All outputs 0 during reset.
- All three valid in the same cycle to r4/r5/r31 with rr=0 → writes in order ALU, MEM, LNK on three consecutive cycles. rr ends at 0. Sources held valid see ready=1 each cycle their slot is granted.
- ALU and MEM both write r9 in the same cycle (0x11, 0x22), then LNK writes r10 → r9=0x11 precedes r9=0x22 regardless of rr, and writeReg=9 never ends with 0x11 last.
- Write to r0 with data 0xDEAD → ready=1, RegWrite never asserts, busy stays 0.
- Fill all slots, assert reset mid-drain → next cycle RegWrite=0, busy=0, all readies=1, no stale write afterwards.
- With REGWRITE_BYPASS_EN: MEM slot holds r7=0x1234 and rd_addr1=7 → byp_hit1=1, byp_data1=0x1234. rd_addr2=0 → byp_hit2=0. Without the macro, byp_hit1=0 throughout.
